generic_counter: RTL and testbench

Parameterised synchronous binary counter, the common building block behind the neural-network sequencing counters that track weights, nodes and layers. It counts clock edges from a reset value and wraps or saturates at a programmable limit. Optional load and direction control are included. Upper-level logic compares `count` against the network shape table and feeds its done strobes back as `reset`.

---
 rtl/generic_counter_pkg.sv | 8 +
 rtl/generic_counter.sv | 85 ++++++++
 tb/tb_generic_counter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/generic_counter_pkg.sv
// Shared counter widths for the network sequencer (weight, node and layer counters).
package generic_counter_pkg;

  localparam int unsigned WEIGHT_WIDTH = 8;
  localparam int unsigned NODE_WIDTH   = 8;
  localparam int unsigned LAYER_WIDTH  = 3;

endpackage

// File: rtl/generic_counter.sv
// Parameterised up/down counter with programmable limit, wrap or saturate at the bound,
// synchronous load and a registered one-cycle wrap pulse.
module generic_counter
  import generic_counter_pkg::*;
#(
  parameter int unsigned              COUNT_WIDTH = 8,
  parameter logic [COUNT_WIDTH-1:0]   RESET_VALUE = '0,
  parameter bit                       SATURATE    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   up,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic [COUNT_WIDTH-1:0] limit,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   at_limit,
  output logic                   wrap
);

  // Declaration initialisers give a usable power-up state without a reset.
  logic [COUNT_WIDTH-1:0] count_q = RESET_VALUE;
  logic                   wrap_q  = 1'b0;
  logic                   held_q  = 1'b0;

  logic [COUNT_WIDTH-1:0] count_d;
  logic                   wrap_d;
  logic                   held_d;

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign at_limit = up ? (count_q == limit) : (count_q == '0);

  // held_q marks a saturated hold so wrap fires only on the first cycle at the bound.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    held_d  = held_q;
    if (reset) begin
      count_d = RESET_VALUE;
      held_d  = 1'b0;
    end else if (load) begin
      count_d = load_value;
      held_d  = 1'b0;
    end else if (en) begin
      if (up) begin
        if (count_q == limit) begin
          if (SATURATE) begin
            wrap_d = ~held_q;
            held_d = 1'b1;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          // Above the limit (only via load) the count runs on to the natural wrap.
          count_d = count_q + COUNT_WIDTH'(1);
          wrap_d  = (count_q > limit) && (count_q == '1);
          held_d  = 1'b0;
        end
      end else begin
        if (count_q == '0) begin
          if (SATURATE) begin
            wrap_d = ~held_q;
            held_d = 1'b1;
          end else begin
            count_d = limit;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - COUNT_WIDTH'(1);
          held_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
    wrap_q  <= wrap_d;
    held_q  <= held_d;
  end

endmodule

// File: tb/tb_generic_counter.sv
// Directed bench: a wrapping and a saturating 3-bit counter driven by the same inputs.
module tb_generic_counter;

  logic       clk = 1'b0;
  logic       reset, en, up, load;
  logic [2:0] load_value, limit;
  logic [2:0] count_w, count_s;
  logic       at_limit_w, at_limit_s, wrap_w, wrap_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  generic_counter #(.COUNT_WIDTH(3), .RESET_VALUE(3'd0), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value), .limit(limit),
    .count(count_w), .at_limit(at_limit_w), .wrap(wrap_w)
  );

  generic_counter #(.COUNT_WIDTH(3), .RESET_VALUE(3'd0), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_value(load_value), .limit(limit),
    .count(count_s), .at_limit(at_limit_s), .wrap(wrap_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string tag, input int c, input int w);
    check({tag, " w.count"}, 32'(count_w), 32'(c));
    check({tag, " w.wrap"},  32'(wrap_w),  32'(w));
  endtask

  task automatic check_s(input string tag, input int c, input int w);
    check({tag, " s.count"}, 32'(count_s), 32'(c));
    check({tag, " s.wrap"},  32'(wrap_s),  32'(w));
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0;
    load_value = 3'd0; limit = 3'd7;

    // Power-up state, then counting with no reset ever applied.
    #1;
    check_w("powerup", 0, 0);
    check_s("powerup", 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_w($sformatf("noreset%0d", i), i, 0);
    end

    // Reset.
    reset = 1'b1;
    tick();
    check_w("reset", 0, 0);
    check_s("reset", 0, 0);
    reset = 1'b0;

    // Free run to limit 7.
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_w($sformatf("free%0d", i), i % 8, (i == 8) ? 1 : 0);
      check($sformatf("free%0d w.at_limit", i), 32'(at_limit_w), (i % 8 == 7) ? 1 : 0);
      check_s($sformatf("free%0d", i), (i <= 7) ? i : 7, (i == 8) ? 1 : 0);
      check($sformatf("free%0d s.at_limit", i), 32'(at_limit_s), (i >= 7) ? 1 : 0);
    end

    // Limit 4: wrap vs saturate.
    reset = 1'b1; limit = 3'd4;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_w($sformatf("lim4_%0d", i), i % 5, (i == 5) ? 1 : 0);
      check_s($sformatf("lim4_%0d", i), (i <= 4) ? i : 4, (i == 5) ? 1 : 0);
      check($sformatf("lim4_%0d s.at_limit", i), 32'(at_limit_s), (i >= 4) ? 1 : 0);
    end

    // Reset beats load.
    load = 1'b1; load_value = 3'd5;
    tick();
    check_w("load5", 5, 0);
    reset = 1'b1; load_value = 3'd3;
    tick();
    check_w("reset_vs_load", 0, 0);
    check_s("reset_vs_load", 0, 0);
    reset = 1'b0;

    // Load above limit then natural wrap: 6,7,0,1.
    load_value = 3'd6;
    tick();
    check_w("over_load", 6, 0);
    load = 1'b0;
    tick();
    check_w("over7", 7, 0);
    check_s("over7", 7, 0);
    tick();
    check_w("over0", 0, 1);
    check_s("over0", 0, 1);
    tick();
    check_w("over1", 1, 0);
    check_s("over1", 1, 0);

    // Down count from 2 with limit 5, with an enable gap.
    load = 1'b1; load_value = 3'd2; limit = 3'd5; up = 1'b0;
    tick();
    load = 1'b0;
    check_w("down2", 2, 0);
    tick();
    check_w("down1", 1, 0);
    en = 1'b0;
    tick();
    check_w("hold_a", 1, 0);
    tick();
    check_w("hold_b", 1, 0);
    check_s("hold_b", 1, 0);
    en = 1'b1;
    tick();
    check_w("down0", 0, 0);
    check("down0 w.at_limit", 32'(at_limit_w), 1);
    tick();
    check_w("down_wrap", 5, 1);
    check_s("down_sat", 0, 1);
    tick();
    check_w("down4", 4, 0);
    check_s("down_hold", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
